// File: rtl/sram_if.sv
// Sequences CE/OE/WE cycles to an asynchronous SRAM with programmable setup/pulse/hold wait states.
// Optional SRAM_BACK2BACK_EN: accept the next request at the completion edge, keeping SRE low between accesses.
module sram_if #(
  parameter int AW    = 11,
  parameter int DW    = 8,
  parameter int SETUP = 1,
  parameter int PULSE = 2,
  parameter int HOLD  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Req,
  input  logic          Wr,
  input  logic [AW-1:0] Addr,
  input  logic [DW-1:0] WrData,
  output logic          Busy,
  output logic          Ack,
  output logic [DW-1:0] RdData,
  output logic [AW-1:0] SrAddr,
  inout  wire  [DW-1:0] SrData,
  output logic          SRE,
  output logic          SRG,
  output logic          SRW
);

  if (SETUP < 1 || SETUP > 15) begin : g_bad_setup
    $error("sram_if: SETUP must be 1..15");
  end
  if (PULSE < 1 || PULSE > 15) begin : g_bad_pulse
    $error("sram_if: PULSE must be 1..15");
  end
  if (HOLD < 0 || HOLD > 15) begin : g_bad_hold
    $error("sram_if: HOLD must be 0..15");
  end

  localparam logic [3:0] SETUP_LD = 4'(SETUP - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE - 1);
  localparam logic [3:0] HOLD_LD  = (HOLD == 0) ? 4'd0 : 4'(HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          wr_lat;
  logic          drive;
  logic [DW-1:0] wr_dat;
  logic          last;
  logic          accept;

  // Final cycle of an access: the next edge is the completion edge.
  assign last = (cnt == 4'd0) &&
                ((state == S_HOLD) || ((state == S_PULSE) && (HOLD == 0)));

`ifdef SRAM_BACK2BACK_EN
  assign Busy = (state != S_IDLE) && !last;
`else
  assign Busy = (state != S_IDLE);
`endif

  assign accept = Req && !Busy;
  assign SrData = drive ? wr_dat : {DW{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      wr_lat <= 1'b0;
      drive  <= 1'b0;
      wr_dat <= '0;
      SrAddr <= '0;
      RdData <= '0;
      Ack    <= 1'b0;
      SRE    <= 1'b1;
      SRG    <= 1'b1;
      SRW    <= 1'b1;
    end else begin
      Ack <= 1'b0;
      case (state)
        S_SETUP: begin
          if (cnt == 4'd0) begin
            state <= S_PULSE;
            cnt   <= PULSE_LD;
            SRG   <= wr_lat;
            SRW   <= !wr_lat;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_PULSE: begin
          if (cnt == 4'd0) begin
            SRG <= 1'b1;
            SRW <= 1'b1;
            if (!wr_lat) RdData <= SrData;
            state <= S_HOLD;
            cnt   <= HOLD_LD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        default: ;
      endcase

      // Completion overrides the per-state transition (covers HOLD=0 from PULSE).
      if (last) begin
        Ack   <= 1'b1;
        state <= S_IDLE;
        SRE   <= 1'b1;
        drive <= 1'b0;
      end

      // A new request wins over the return to idle when back-to-back is enabled.
      if (accept) begin
        state  <= S_SETUP;
        cnt    <= SETUP_LD;
        SRE    <= 1'b0;
        SrAddr <= Addr;
        wr_lat <= Wr;
        wr_dat <= WrData;
        drive  <= Wr;
      end
    end
  end

endmodule

// File: tb/tb_sram_if.sv
// Bench for sram_if: default timing, a 3/4/0 wait-state instance and a 16-bit wide instance, each with an SRAM model.
module tb_sram_if;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic        req_a, wr_a, busy_a, ack_a, sre_a, srg_a, srw_a;
  logic [10:0] addr_a, sa_a;
  logic [7:0]  wd_a, rd_a;
  wire  [7:0]  sd_a;
  // Instance B: SETUP=3, PULSE=4, HOLD=0
  logic        req_b, wr_b, busy_b, ack_b, sre_b, srg_b, srw_b;
  logic [10:0] addr_b, sa_b;
  logic [7:0]  wd_b, rd_b;
  wire  [7:0]  sd_b;
  // Instance C: AW=16, DW=16
  logic        req_c, wr_c, busy_c, ack_c, sre_c, srg_c, srw_c;
  logic [15:0] addr_c, sa_c;
  logic [15:0] wd_c, rd_c;
  wire  [15:0] sd_c;

  sram_if dut_a (
    .clk(clk), .rst_n(rst_n), .Req(req_a), .Wr(wr_a), .Addr(addr_a), .WrData(wd_a),
    .Busy(busy_a), .Ack(ack_a), .RdData(rd_a), .SrAddr(sa_a), .SrData(sd_a),
    .SRE(sre_a), .SRG(srg_a), .SRW(srw_a));

  sram_if #(.SETUP(3), .PULSE(4), .HOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .Req(req_b), .Wr(wr_b), .Addr(addr_b), .WrData(wd_b),
    .Busy(busy_b), .Ack(ack_b), .RdData(rd_b), .SrAddr(sa_b), .SrData(sd_b),
    .SRE(sre_b), .SRG(srg_b), .SRW(srw_b));

  sram_if #(.AW(16), .DW(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .Req(req_c), .Wr(wr_c), .Addr(addr_c), .WrData(wd_c),
    .Busy(busy_c), .Ack(ack_c), .RdData(rd_c), .SrAddr(sa_c), .SrData(sd_c),
    .SRE(sre_c), .SRG(srg_c), .SRW(srw_c));

  // Asynchronous SRAM models: drive on CE&OE, capture while CE&WE are low.
  logic [7:0]  mem_a [0:2047];
  logic [7:0]  mem_b [0:2047];
  logic [15:0] mem_c [0:65535];
  assign sd_a = (!sre_a && !srg_a) ? mem_a[sa_a] : 8'bz;
  assign sd_b = (!sre_b && !srg_b) ? mem_b[sa_b] : 8'bz;
  assign sd_c = (!sre_c && !srg_c) ? mem_c[sa_c] : 16'bz;
  always @(posedge clk) begin
    if (!sre_a && !srw_a) mem_a[sa_a] <= sd_a;
    if (!sre_b && !srw_b) mem_b[sa_b] <= sd_b;
    if (!sre_c && !srw_c) mem_c[sa_c] <= sd_c;
  end

  int sel;
  logic m_ack, m_busy, m_sre, m_srg, m_srw;
  logic [15:0] m_rd, m_sa;
  always_comb begin
    m_ack = ack_a; m_busy = busy_a; m_sre = sre_a; m_srg = srg_a; m_srw = srw_a;
    m_rd = 16'(rd_a); m_sa = 16'(sa_a);
    if (sel == 1) begin
      m_ack = ack_b; m_busy = busy_b; m_sre = sre_b; m_srg = srg_b; m_srw = srw_b;
      m_rd = 16'(rd_b); m_sa = 16'(sa_b);
    end else if (sel == 2) begin
      m_ack = ack_c; m_busy = busy_c; m_sre = sre_c; m_srg = srg_c; m_srw = srw_c;
      m_rd = rd_c; m_sa = sa_c;
    end
  end

  typedef struct {
    int          due;
    logic        rd;
    logic [15:0] data;
  } sb_t;
  sb_t sb[$];

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic overlap = 1'b0;
  logic saw7ff = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    case (sel)
      0: begin req_a = r; wr_a = w; addr_a = a[10:0]; wd_a = d[7:0]; end
      1: begin req_b = r; wr_b = w; addr_b = a[10:0]; wd_b = d[7:0]; end
      default: begin req_c = r; wr_c = w; addr_c = a; wd_c = d; end
    endcase
  endtask

  // Advance one edge, sample 1 time unit later, retire any Ack against the scoreboard.
  task automatic step();
    sb_t e;
    @(posedge clk);
    cyc++;
    #1;
    if ((!srg_a && !srw_a) || (!srg_b && !srw_b) || (!srg_c && !srw_c)) overlap = 1'b1;
    if (sa_a == 11'h7FF) saw7ff = 1'b1;
    if (m_ack) begin
      chk("ack_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_latency", 32'(cyc), 32'(e.due));
        if (e.rd) chk("rd_data", 32'(m_rd), 32'(e.data));
      end
    end
  endtask

  // mode 1: stray Req (addr 0x7FF) one cycle after acceptance; mode 2: stray Req in the final cycle.
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input int lat, input int mode,
                        output int n_sre, output int n_srg, output int n_srw,
                        output int srg_first, output int srg_last);
    int e0;
    int idx;
    n_sre = 0; n_srg = 0; n_srw = 0; srg_first = 0; srg_last = 0;
    drive(1'b1, w, a, d);
    e0 = cyc + 1;
    sb.push_back('{e0 + lat, !w, d});
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      step();
      idx = cyc - e0 + 1;
      if ((mode == 1 && idx == 1) || (mode == 2 && idx == lat))
        drive(1'b1, 1'b1, 16'h07FF, 16'h00FF);
      else
        drive(1'b0, w, a, d);
      if (!m_sre) n_sre++;
      if (!m_srw) n_srw++;
      if (!m_srg) begin
        if (srg_first == 0) srg_first = idx;
        srg_last = idx;
      end
      if (!m_srg) n_srg++;
    end
    drive(1'b0, w, a, d);
    chk("ack_arrived", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns, ng, nw, gf, gl, nlow;
    rst_n = 1'b0;
    sel = 0; drive(1'b0, 1'b0, 16'h0, 16'h0);
    sel = 1; drive(1'b0, 1'b0, 16'h0, 16'h0);
    sel = 2; drive(1'b0, 1'b0, 16'h0, 16'h0);
    sel = 0;
    repeat (3) step();
    chk("rst_sre", 32'(sre_a), 32'd1);
    chk("rst_srg", 32'(srg_a), 32'd1);
    chk("rst_srw", 32'(srw_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_rddata", 32'(rd_a), 32'd0);
    chk("rst_sraddr", 32'(sa_a), 32'd0);
    rst_n = 1'b1;
    step();

    // Reset asserted mid-PULSE of a write aborts it without an Ack.
    drive(1'b1, 1'b1, 16'h0200, 16'h00C3);
    step();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    chk("busy_after_accept", 32'(busy_a), 32'd1);
    step();
    chk("srw_in_pulse", 32'(srw_a), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_srw", 32'(srw_a), 32'd1);
    chk("abort_sre", 32'(sre_a), 32'd1);
    chk("abort_srg", 32'(srg_a), 32'd1);
    chk("abort_busy", 32'(busy_a), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (6) step();

    // Default timing: write then read back.
    access(1'b1, 16'h0123, 16'h005A, 4, 0, ns, ng, nw, gf, gl);
    chk("wr_srw_low_cycles", 32'(nw), 32'd2);
    chk("wr_sre_low_cycles", 32'(ns), 32'd4);
    chk("wr_srg_low_cycles", 32'(ng), 32'd0);
    chk("sre_high_after_ack", 32'(m_sre), 32'd1);
    step();
    access(1'b0, 16'h0123, 16'h005A, 4, 0, ns, ng, nw, gf, gl);
    chk("rd_srg_low_cycles", 32'(ng), 32'd2);
    chk("rd_srw_low_cycles", 32'(nw), 32'd0);
    chk("rd_sre_low_cycles", 32'(ns), 32'd4);

    // Req while busy is dropped.
    access(1'b0, 16'h0123, 16'h005A, 4, 1, ns, ng, nw, gf, gl);
    repeat (6) step();

`ifdef SRAM_BACK2BACK_EN
    // Four writes then four reads, each request landing in the final cycle of the previous.
    nlow = 0;
    for (int t = 0; t < 36; t++) begin
      if (t < 32 && t % 4 == 0) begin
        drive(1'b1, t < 16, 16'((t / 4) % 4), 16'((t / 4) % 4));
        sb.push_back('{cyc + 1 + 4, t >= 16, 16'((t / 4) % 4)});
      end else begin
        drive(1'b0, 1'b0, 16'h0, 16'h0);
      end
      step();
      if (t < 32 && !sre_a) nlow++;
    end
    chk("b2b_sre_low_cycles", 32'(nlow), 32'd32);
    chk("b2b_all_acked", 32'(sb.size()), 32'd0);
    sb.delete();
`else
    // A Req in the final cycle is still refused; a wrongful accept would produce an unexpected Ack.
    access(1'b0, 16'h0123, 16'h005A, 4, 2, ns, ng, nw, gf, gl);
    repeat (6) step();
    nlow = 0;
`endif

    // Wait-state sweep on instance B.
    sel = 1;
    step();
    access(1'b1, 16'h0045, 16'h0096, 7, 0, ns, ng, nw, gf, gl);
    chk("ws_wr_sre_low", 32'(ns), 32'd7);
    chk("ws_wr_srw_low", 32'(nw), 32'd4);
    step();
    access(1'b0, 16'h0045, 16'h0096, 7, 0, ns, ng, nw, gf, gl);
    chk("ws_rd_sre_low", 32'(ns), 32'd7);
    chk("ws_rd_srg_low", 32'(ng), 32'd4);
    chk("ws_rd_srg_first", 32'(gf), 32'd4);
    chk("ws_rd_srg_last", 32'(gl), 32'd7);

    // Wide instance: top address and address zero hold distinct data.
    sel = 2;
    step();
    access(1'b1, 16'hFFFF, 16'hBEEF, 4, 0, ns, ng, nw, gf, gl);
    step();
    access(1'b1, 16'h0000, 16'h1234, 4, 0, ns, ng, nw, gf, gl);
    step();
    access(1'b0, 16'hFFFF, 16'hBEEF, 4, 0, ns, ng, nw, gf, gl);
    step();
    access(1'b0, 16'h0000, 16'h1234, 4, 0, ns, ng, nw, gf, gl);
    chk("wide_sraddr_last", 32'(m_sa), 32'h0000);
    repeat (4) step();

    chk("no_oe_we_overlap", 32'(overlap), 32'd0);
    chk("dropped_addr_never_driven", 32'(saw7ff), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
